// File: rtl/wb_skid_stage_pkg.sv
// Shared constants and state encoding for the writeback skid stage.
// Holds the zero word, polarity constants and the FSM state type.
package wb_skid_stage_pkg;

  localparam logic [63:0] ZERO_WORD = '0;
  localparam logic RST_ACTIVE = 1'b1;
  localparam logic WE_ACTIVE  = 1'b1;
  localparam logic WE_OFF     = ~WE_ACTIVE;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/wb_skid_stage_entry_reg.sv
// One writeback entry register: {rd_enable, rd_addr, rd_data}.
// Ports: clk, rst (sync, high), clear (sync), load, d, q.
module wb_entry_reg
  import wb_skid_stage_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE || clear)
      q <= W'(ZERO_WORD);
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/wb_skid_stage.sv
// Two-entry skid buffer between MEM and WB with newest-write forwarding.
// Ports: clk/rst, flush, in_* (MEM), out_* (WB head), fwd_*, occupancy.
module wb_skid_stage
  import wb_skid_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DROP_X0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rd_data,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic              in_rd_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd_data,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic              out_rd_enable,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  localparam int EW = DATA_W + ADDR_W + 1;

  state_t state;

  logic accept;
  logic pop;
  logic in_en;
  logic head_load;
  logic skid_load;
  logic head_from_skid;

  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_d;
  logic [EW-1:0] head_q;
  logic [EW-1:0] skid_q;

  assign in_ready  = (state != ST_TWO) && (rst != RST_ACTIVE);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // x0 writes keep data/addr but never reach the register file
  always_comb begin
    in_en = (in_rd_enable == WE_ACTIVE);
    if (DROP_X0 != 0 && in_rd_addr == '0)
      in_en = WE_OFF;
  end

  assign in_entry = {in_en, in_rd_addr, in_rd_data};
  assign head_d   = head_from_skid ? skid_q : in_entry;

  always_comb begin
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    unique case (state)
      ST_EMPTY: head_load = accept;
      ST_ONE: begin
        if (accept && pop)
          head_load = 1'b1;
        else if (accept)
          skid_load = 1'b1;
      end
      ST_TWO: begin
        head_load      = pop;
        head_from_skid = pop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (accept) state <= ST_ONE;
        ST_ONE: begin
          if (accept && !pop)
            state <= ST_TWO;
          else if (!accept && pop)
            state <= ST_EMPTY;
        end
        ST_TWO: if (pop) state <= ST_ONE;
        default: state <= ST_EMPTY;
      endcase
    end
  end

  wb_entry_reg #(.W(EW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (head_load),
    .d     (head_d),
    .q     (head_q)
  );

  wb_entry_reg #(.W(EW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign out_rd_data   = head_q[DATA_W-1:0];
  assign out_rd_addr   = head_q[DATA_W +: ADDR_W];
  assign out_rd_enable = head_q[EW-1];

  // newest held entry is SKID when two are held, else HEAD
  always_comb begin
    fwd_addr  = head_q[DATA_W +: ADDR_W];
    fwd_data  = head_q[DATA_W-1:0];
    fwd_valid = 1'b0;
    unique case (state)
      ST_ONE: fwd_valid = head_q[EW-1];
      ST_TWO: begin
        fwd_addr  = skid_q[DATA_W +: ADDR_W];
        fwd_data  = skid_q[DATA_W-1:0];
        fwd_valid = skid_q[EW-1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_skid_stage.sv
// Self-checking bench for wb_skid_stage: vector table plus scoreboard.
// Vectors give inputs and the pre-edge state they expect.
module tb_wb_skid_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rd_data;
  logic [4:0]  in_rd_addr;
  logic        in_rd_enable;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rd_data;
  logic [4:0]  out_rd_addr;
  logic        out_rd_enable;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [1:0]  occupancy;

  int n_chk;
  int n_fail;

  typedef struct {
    logic        r;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [4:0]  a;
    logic [31:0] d;
    logic        en;
    logic [1:0]  occ;
    logic        rdy;
    logic        fv;
    logic [4:0]  fa;
    logic [31:0] fd;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic        en;
  } ent_t;

  vec_t tbl[$];
  ent_t sb[$];

  wb_skid_stage dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd_data    (in_rd_data),
    .in_rd_addr    (in_rd_addr),
    .in_rd_enable  (in_rd_enable),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rd_data   (out_rd_data),
    .out_rd_addr   (out_rd_addr),
    .out_rd_enable (out_rd_enable),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic fl, input logic iv, input logic ordy,
    input logic [4:0] a, input logic [31:0] d, input logic en,
    input logic [1:0] occ, input logic rdy, input logic fv,
    input logic [4:0] fa, input logic [31:0] fd);
    vec_t v;
    v.r = r; v.fl = fl; v.iv = iv; v.ordy = ordy;
    v.a = a; v.d = d; v.en = en;
    v.occ = occ; v.rdy = rdy; v.fv = fv; v.fa = fa; v.fd = fd;
    return v;
  endfunction

  initial begin
    ent_t e;
    ent_t h;
    n_chk = 0;
    n_fail = 0;

    // r fl iv or addr data en | occ rdy fv fa fd
    tbl.push_back(mk(0,0,1,1, 3,32'hA5,1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,1, 4,32'h5A,1, 1,1,1,3,32'hA5));
    tbl.push_back(mk(0,0,0,1, 0,0,0,      1,1,1,4,32'h5A));
    tbl.push_back(mk(0,0,0,1, 0,0,0,      0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 1,32'h11,1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 2,32'h22,1, 1,1,1,1,32'h11));
    tbl.push_back(mk(0,0,1,0, 7,32'h33,1, 2,0,1,2,32'h22));
    tbl.push_back(mk(0,0,1,0, 7,32'h33,1, 2,0,1,2,32'h22));
    tbl.push_back(mk(0,0,1,1, 7,32'h33,1, 2,0,1,2,32'h22));
    tbl.push_back(mk(0,0,1,1, 7,32'h33,1, 1,1,1,2,32'h22));
    tbl.push_back(mk(0,0,0,1, 0,0,0,      1,1,1,7,32'h33));
    tbl.push_back(mk(0,0,0,1, 0,0,0,      0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 0,32'hFF,1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,      1,1,0,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,      1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,      0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 9,32'h99,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,      1,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 5,32'h55,1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 6,32'h77,1, 1,1,1,5,32'h55));
    tbl.push_back(mk(0,0,0,0, 0,0,0,      2,0,1,6,32'h77));
    tbl.push_back(mk(0,0,0,1, 0,0,0,      2,0,1,6,32'h77));
    tbl.push_back(mk(0,0,0,0, 0,0,0,      1,1,1,6,32'h77));
    tbl.push_back(mk(0,0,0,1, 0,0,0,      1,1,1,6,32'h77));
    tbl.push_back(mk(0,0,1,0, 1,32'h01,1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 2,32'h02,1, 1,1,1,1,32'h01));
    tbl.push_back(mk(0,1,1,0, 3,32'h03,1, 2,0,1,2,32'h02));
    tbl.push_back(mk(0,0,0,0, 0,0,0,      0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 8,32'h08,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,1,1, 9,32'h09,1, 1,1,1,8,32'h08));
    tbl.push_back(mk(0,0,0,0, 0,0,0,      0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,10,32'h0A,1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,11,32'h0B,1, 1,1,1,10,32'h0A));
    tbl.push_back(mk(1,0,1,0,12,32'h0C,1, 2,0,1,11,32'h0B));
    tbl.push_back(mk(0,0,0,0, 0,0,0,      0,1,0,0,0));

    // reset held two edges with traffic offered
    rst = 1; flush = 0; in_valid = 1; out_ready = 1;
    in_rd_addr = 5'd3; in_rd_data = 32'hDEAD; in_rd_enable = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_rd_data, 0);
    chk("rst_out_addr", out_rd_addr, 0);
    chk("rst_out_en", out_rd_enable, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_addr", fwd_addr, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_occ", occupancy, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge clk);
      rst          = tbl[i].r;
      flush        = tbl[i].fl;
      in_valid     = tbl[i].iv;
      out_ready    = tbl[i].ordy;
      in_rd_addr   = tbl[i].a;
      in_rd_data   = tbl[i].d;
      in_rd_enable = tbl[i].en;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("v%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].occ != 0);
      chk($sformatf("v%0d_fwd_valid", i), fwd_valid, tbl[i].fv);
      if (tbl[i].fv) begin
        chk($sformatf("v%0d_fwd_addr", i), fwd_addr, tbl[i].fa);
        chk($sformatf("v%0d_fwd_data", i), fwd_data, tbl[i].fd);
      end
      if (tbl[i].ordy && tbl[i].occ != 0 && !tbl[i].r) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_sb_nonempty", i), 0, 1);
        end else begin
          h = sb.pop_front();
          chk($sformatf("v%0d_pop_data", i), out_rd_data, h.d);
          chk($sformatf("v%0d_pop_addr", i), out_rd_addr, h.a);
          chk($sformatf("v%0d_pop_en", i), out_rd_enable, h.en);
        end
      end
      if (tbl[i].r || tbl[i].fl) begin
        sb.delete();
      end else if (tbl[i].iv && tbl[i].rdy) begin
        e.d  = tbl[i].d;
        e.a  = tbl[i].a;
        e.en = tbl[i].en && (tbl[i].a != 5'd0);
        sb.push_back(e);
      end
    end

    @(negedge clk);
    chk("post_rst_out_data", out_rd_data, 0);
    chk("post_rst_out_addr", out_rd_addr, 0);
    chk("post_rst_fwd_addr", fwd_addr, 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_skid_stage.md
WB_SKID_STAGE -- requirements
Module: wb_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, writeback data width.
REQ-002 Parameter ADDR_W, default 5, destination register address width.
REQ-003 Parameter DROP_X0, default 1, suppresses writes to address 0 when 1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard all held entries.
REQ-007 in_valid  input  1  upstream (MEM) entry valid.
REQ-008 in_ready  output  1  stage accepts an entry this cycle.
REQ-009 in_rd_data / in_rd_addr / in_rd_enable  input  DATA_W / ADDR_W / 1  MEM result.
REQ-010 out_valid  output  1  head entry valid toward WB.
REQ-011 out_ready  input  1  WB consumes head this cycle.
REQ-012 out_rd_data / out_rd_addr / out_rd_enable  output  DATA_W / ADDR_W / 1  head entry, registered.
REQ-013 fwd_valid / fwd_addr / fwd_data  output  1 / ADDR_W / DATA_W  newest held write, for hazard forwarding.
REQ-014 occupancy  output  2  entries held (0..2).

Function
REQ-015 Two-entry skid: HEAD register drives out_*; SKID register holds an overflow entry.
REQ-016 States: EMPTY (0 held), ONE (HEAD only), TWO (HEAD+SKID); occupancy equals state count.
REQ-017 in_ready = 1 in EMPTY and ONE, 0 in TWO and while rst = 1; combinational from state only, never from out_ready.
REQ-018 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 EMPTY: accept -> ONE, HEAD loads input; no accept -> stay.
REQ-020 ONE: accept & pop -> ONE, HEAD loads input; accept only -> TWO, SKID loads input; pop only -> EMPTY; neither -> stay.
REQ-021 TWO: pop -> ONE, HEAD loads SKID; no pop -> stay, both registers hold.
REQ-022 out_valid = 1 in ONE and TWO; out_* change only on a load, never glitch mid-cycle.
REQ-023 Latency: accepted entry visible on out_* the cycle after acceptance when stage was EMPTY or popped in ONE.
REQ-024 Ordering strictly FIFO; no entry dropped or duplicated absent flush/reset.
REQ-025 DROP_X0 = 1: entry with in_rd_addr = 0 is stored with rd_enable forced 0; data and addr kept.
REQ-026 Entries with in_rd_enable = 0 still occupy a slot and flow through (bubble-carrying).
REQ-027 flush = 1: next state EMPTY; input that cycle discarded; pop that cycle still counts as consumed by WB.
REQ-028 fwd_*: in TWO reflect SKID, in ONE reflect HEAD, in EMPTY fwd_valid = 0; fwd_valid = 0 if newest entry has rd_enable = 0.
REQ-029 Widths exact; no arithmetic; occupancy never exceeds 2.

Reset
REQ-030 rst = 1 at clock edge: state EMPTY, HEAD and SKID data/addr = 0, rd_enable = 0.
REQ-031 Reset values: out_valid 0, out_rd_data 0, out_rd_addr 0, out_rd_enable 0, fwd_valid 0, fwd_addr 0, fwd_data 0, occupancy 0, in_ready 0.
REQ-032 rst has priority over flush and all handshakes; reset mid-operation discards held entries with no partial write.

Structure
REQ-033 Shared package holds ZERO_WORD, reset/write-enable polarity constants and the state encoding (EMPTY=0, ONE=1, TWO=2, 2 bits).
REQ-034 One sub-module, wb_entry_reg (DATA_W+ADDR_W+1 register with load enable and synchronous clear), instantiated for HEAD and SKID.
REQ-035 Target 120-400 RTL lines; no latches; single clock domain.

Verification
REQ-036 Reset: rst high 2 cycles, in_valid = 1 -> all outputs 0, in_ready 0, occupancy 0.
REQ-037 Streaming: out_ready = 1, push addr 3/data 0xA5, addr 4/data 0x5A back-to-back -> out_* show each one cycle later, occupancy stays 1.
REQ-038 Backpressure: out_ready = 0, push 3 entries -> occupancy 2, in_ready 0, third stalled; release -> order 1,2,3 preserved.
REQ-039 X0: push addr 0, enable 1, data 0xFF -> out_rd_enable 0, fwd_valid 0.
REQ-040 Flush in TWO with in_valid = 1 -> next cycle occupancy 0, out_valid 0, input lost.
REQ-041 Forwarding: TWO with HEAD addr 5 and SKID addr 6/data 0x77 -> fwd_addr 6, fwd_data 0x77; after pop, fwd still 6.
